eea_ctrl: RTL
=============

EEA_CTRL -- requirements
Module: eea_ctrl

Interface
REQ-001 Parameter M, default 163, SHALL set the field degree m of GF(2^m); legal range 2..571.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 Start  input  1  SHALL request one inversion; sampled only in IDLE.
REQ-005 inStop  input  1  SHALL carry the leading bit s_m of the S register from the bit-cell array.
REQ-006 inUmsb, inUlsb  input  1 each  SHALL carry bit m-1 and bit 0 of the U register.
REQ-007 Load  output  1  SHALL command the array to load R=F, S=A, U=0, V=1.
REQ-008 Switch, Reduce, MultU, Carry  output  1 each  SHALL be the per-cycle array control lines.
REQ-009 Busy  output  1  SHALL be high from the LOAD state through the last RUN cycle.
REQ-010 Done  output  1  SHALL pulse for one cycle when the result register holds A^-1.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, RUN, DONE; encoding is free.
REQ-012 IDLE->LOAD SHALL occur on Start=1; otherwise IDLE holds.
REQ-013 LOAD SHALL last exactly one cycle with Load=1, clearing iteration counter to 0 and delta to 0.
REQ-014 RUN SHALL last exactly 2*M cycles regardless of operand value (constant time).
REQ-015 In RUN, inStop=0: Switch=0, Reduce=0, MultU=1, delta<=delta+1.
REQ-016 In RUN, inStop=1 and delta=0: Switch=1, Reduce=1, MultU=0, delta<=1.
REQ-017 In RUN, inStop=1 and delta>0: Switch=0, Reduce=1, MultU=0, delta<=delta-1.
REQ-018 Carry SHALL equal inUmsb when MultU=1 and inUlsb when MultU=0; combinational from inputs and state.
REQ-019 delta SHALL be unsigned, width clog2(2*M+1), and never wrap; saturate at 2*M (unreachable in legal operation).
REQ-020 After counter reaches 2*M-1 in RUN, next state SHALL be DONE; DONE lasts one cycle with Done=1, then IDLE.
REQ-021 Outside RUN, Switch, Reduce, MultU, Carry SHALL be 0 (array holds).
REQ-022 Start while Busy or in DONE SHALL be ignored, not queued.
REQ-023 Total latency Start-to-Done SHALL be 2*M+2 cycles.
REQ-024 A=0 input is out of contract; controller still completes in 2*M+2 cycles.

Reset
REQ-025 rst_n=0 SHALL force IDLE, counter=0, delta=0, all outputs 0, asynchronously.
REQ-026 Reset mid-RUN SHALL abandon the operation with no Done pulse.
REQ-027 Reset deassertion SHALL be synchronised externally; first Start accepted on the first edge after release.

Configuration
REQ-028 Macro EEA_CTRL_ABORT_EN SHALL add input Abort (1 bit).
REQ-029 With EEA_CTRL_ABORT_EN: Abort=1 in LOAD or RUN SHALL return to IDLE next cycle, Busy low, no Done; Abort in IDLE/DONE ignored; Abort beats Start.
REQ-030 Without EEA_CTRL_ABORT_EN: port absent, behaviour per REQ-011..REQ-024.

Structure
REQ-031 Shared package eea_pkg SHALL hold the state enum, default M, and DELTA_W/CNT_W width functions.
REQ-032 One sub-module eea_iter_cnt (counter with terminal-count flag) is natural; the FSM stays in eea_ctrl.

Verification
REQ-033 M=4, Start pulse -> Load high cycle 1, Busy cycles 1..9, Done exactly at cycle 10.
REQ-034 M=4, inStop held 0 all RUN -> MultU=1, Reduce=0, Switch=0 every RUN cycle; delta ends at 8 without wrap.
REQ-035 M=4, inStop pattern 1,1,0,1 -> Switch=1 cycle 1 only; delta sequence 1,0,1,0; Reduce=1,1,0,1.
REQ-036 MultU=1 with inUmsb=1,inUlsb=0 -> Carry=1; MultU=0 same inputs -> Carry=0.
REQ-037 rst_n low at RUN cycle 3 -> outputs 0 immediately, no Done, next Start gives full 2*M+2 latency.
REQ-038 EEA_CTRL_ABORT_EN: Abort at RUN cycle 5 with Start also high -> IDLE next cycle, no Done, Start not accepted that cycle.

Source files
------------

// File: rtl/eea_pkg.sv
// Shared types and width helpers for the GF(2^m) extended-Euclid inversion controller.
package eea_pkg;

  localparam int unsigned M_DEFAULT = 163;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } ctrlState_t;

  // delta spans 0..2m inclusive
  function automatic int unsigned DELTA_W(input int unsigned m);
    return $clog2(2 * m + 1);
  endfunction

  // iteration counter spans 0..2m-1
  function automatic int unsigned CNT_W(input int unsigned m);
    return $clog2(2 * m);
  endfunction

endpackage

// File: rtl/eea_ctrl_if.sv
// Handshake and per-cycle control lines between the inversion controller and its bit-cell array.
interface eea_ctrl_if;
  logic Start;
  logic inStop;
  logic inUmsb;
  logic inUlsb;
  logic Load;
  logic Switch;
  logic Reduce;
  logic MultU;
  logic Carry;
  logic Busy;
  logic Done;

  modport master (
    input  Start, inStop, inUmsb, inUlsb,
    output Load, Switch, Reduce, MultU, Carry, Busy, Done
  );

  modport slave (
    output Start, inStop, inUmsb, inUlsb,
    input  Load, Switch, Reduce, MultU, Carry, Busy, Done
  );
endinterface

// File: rtl/eea_iter_cnt.sv
// Iteration counter for the RUN phase; holds at LAST and flags it as terminal count.
module eea_iter_cnt #(
  parameter int unsigned W    = 4,
  parameter int unsigned LAST = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/eea_ctrl.sv
// Constant-time (2*M RUN cycles) controller for a GF(2^M) extended-Euclid inverter bit-cell array.
// Optional EEA_CTRL_ABORT_EN adds an Abort input that cancels LOAD/RUN back to IDLE.
module eea_ctrl
  import eea_pkg::*;
#(
  parameter int unsigned M = M_DEFAULT
) (
  input logic        clk,
  input logic        rst_n,
  eea_ctrl_if.master bus
`ifdef EEA_CTRL_ABORT_EN
  ,
  input logic        Abort
`endif
);

  localparam int unsigned DW = DELTA_W(M);
  localparam int unsigned CW = CNT_W(M);
  localparam logic [DW-1:0] DMAX = DW'(2 * M);

  ctrlState_t state, stateNext;
  logic [DW-1:0] delta, deltaNext;
  logic [CW-1:0] cnt;
  logic cntTc, cntClr, cntEn;
  logic load, switchC, reduce, multU, carry, busy, done;

  eea_iter_cnt #(
    .W    (CW),
    .LAST (2 * M - 1)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cntClr),
    .en    (cntEn),
    .cnt   (cnt),
    .tc    (cntTc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      delta <= '0;
    end else begin
      state <= stateNext;
      delta <= deltaNext;
    end
  end

  always_comb begin
    stateNext = state;
    deltaNext = delta;
    cntClr    = 1'b0;
    cntEn     = 1'b0;
    load      = 1'b0;
    switchC   = 1'b0;
    reduce    = 1'b0;
    multU     = 1'b0;
    carry     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) stateNext = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        busy      = 1'b1;
        cntClr    = 1'b1;
        deltaNext = '0;
        stateNext = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        cntEn = 1'b1;
        if (!bus.inStop) begin
          multU     = 1'b1;
          deltaNext = (delta != DMAX) ? delta + DW'(1) : delta;
        end else if (delta == '0) begin
          switchC   = 1'b1;
          reduce    = 1'b1;
          deltaNext = DW'(1);
        end else begin
          reduce    = 1'b1;
          deltaNext = delta - DW'(1);
        end
        carry = multU ? bus.inUmsb : bus.inUlsb;
        if (cntTc) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
`ifdef EEA_CTRL_ABORT_EN
    if (Abort && (state == LOAD || state == RUN)) stateNext = IDLE;
`endif
  end

  assign bus.Load   = load;
  assign bus.Switch = switchC;
  assign bus.Reduce = reduce;
  assign bus.MultU  = multU;
  assign bus.Carry  = carry;
  assign bus.Busy   = busy;
  assign bus.Done   = done;

endmodule
